bs_bp_shading_light_seq: RTL and testbench
==========================================

# bs_bp_shading_light_seq

Sequencer for the per-light shading datapath. When a shading request starts, it walks the light-source table one light at a time. For each light it feeds one shared `bs_bp_shading_light` unit, accumulates the per-light RGB results, adds the ambient term, and emits one saturated RGB result. It sits between the hit/normal stage of `bs_bp_shading` and the pixel writer, so that one costly normalize/dot/multiply unit is time-shared across up to MAX_L lights.

## Interface
Parameters:
- MAX_L, 8, maximum light sources supported.
- LEN_N, $clog2(MAX_L+1), width of the light count (0..MAX_L inclusive).
- LEN_A, $clog2(MAX_L), width of the light-table address.

Ports. One clock; reset is synchronous and active-low.
- i_clk  in  1  clock, all state on rising edge.
- i_rstn  in  1  synchronous active-low reset.
- i_en  in  1  start pulse; sampled only in IDLE.
- i_num_lights  in  LEN_N  lights to process; captured at start.
- i_amb_light [0:2]  in  32 signed  ambient RGB (16.16 fixed point); captured at start.
- o_light_rd_addr  out  LEN_A  light-table read address; table read latency is exactly 1 cycle.
- i_light_rd_data [0:1][0:2]  in  32 signed  table data: [0] source position, [1] color.
- o_unit_light [0:1][0:2]  out  32 signed  registered light handed to the shared unit; stable from LATCH through WAIT.
- o_unit_en  out  1  one-cycle start pulse to the shared unit.
- i_unit_light [0:2]  in  32 signed  per-light RGB from the unit (unclamped).
- i_unit_valid  in  1  unit result valid; sampled only in WAIT.
- o_light [0:2]  out  32 signed  final RGB, range [0, 0x0000ffff].
- o_busy  out  1  high in every state except IDLE.
- o_valid  out  1  one-cycle pulse; o_light is valid while it is high.

## Operation
- States:
  - IDLE: wait for i_en. On i_en, capture count and ambient, clear the index and accumulators. Go to RD if count > 0, otherwise go to DONE.
  - RD: drive o_light_rd_addr = idx. Go to LATCH.
  - LATCH: register i_light_rd_data into o_unit_light. Go to ISSUE.
  - ISSUE: o_unit_en = 1 for this cycle only. Go to WAIT.
  - WAIT: hold until i_unit_valid. On valid, accumulate and increment idx. Go to RD if idx+1 < count, otherwise go to DONE.
  - DONE: o_valid = 1. Go to IDLE.
- Accumulation (per channel):
  - A negative i_unit_light term is treated as 0.
  - acc = min(acc + term, 0x0000ffff). Compute in 33 bits so no intermediate wraps.
- Final value, registered on the transition into DONE:
  - o_light = clamp(amb + acc, 0, 0x0000ffff), computed in 33-bit signed.
  - A negative ambient can therefore yield 0.
- o_light holds its value until the next DONE.
- i_num_lights > MAX_L is clamped to MAX_L at capture.
- o_light_rd_addr holds idx in all states and is 0 in IDLE.

## Timing
- Reset values: state IDLE, o_light 0 on all channels, o_unit_light 0, o_light_rd_addr 0, o_unit_en 0, o_busy 0, o_valid 0.
- Reset mid-operation: return to IDLE next cycle with all outputs at reset values. No o_valid is emitted.
- Reference points:
  - i_en is sampled high in cycle 0.
  - Unit latency L_u ≥ 1: i_unit_valid arrives L_u cycles after o_unit_en.
- For N lights, o_valid is high in cycle 1 + N·(3 + L_u). For N = 0, that is cycle 1.
- o_busy rises in cycle 1 and falls in the cycle after o_valid.
- Back-to-back requests: i_en in the cycle after o_valid is accepted. i_en while o_busy is ignored; it is not queued.
- i_unit_valid outside WAIT is ignored and does not accumulate.
- i_unit_valid is never sampled in the ISSUE cycle.
- Simultaneous reset and i_en: reset wins.

## Test plan
- **Single light.** amb = {0x2000, 0x2000, 0x2000}, N = 1, unit returns {0x4000, 0x1000, 0} with L_u = 2.
  - o_valid in cycle 6; o_light = {0x6000, 0x3000, 0x2000}.
  - Exactly one o_unit_en pulse, at cycle 3, with o_light_rd_addr = 0 in cycle 1.
- **Zero lights.** N = 0, amb = {0x1000, 0x2000, 0x3000}.
  - o_valid in cycle 1; o_light equals amb; no o_unit_en pulse.
- **Saturation.** N = 4, each light returns 0x8000 per channel, L_u = 1.
  - o_light = 0x0000ffff on all channels.
  - o_valid at cycle 17; addresses 0, 1, 2, 3 presented in order.
- **Negative inputs.** N = 2, amb = {-0x4000, 0, 0}; light 0 returns {-0x8000, 0x1000, 0}, light 1 returns {0x2000, 0x1000, 0x1000}.
  - o_light = {0, 0x2000, 0x1000}.
- **Protocol robustness.**
  - A stray i_unit_valid during RD is ignored.
  - A second i_en pulse while busy is ignored.
  - Variable L_u (1, 5, 3) across three lights gives the correct sum and o_valid at cycle 1 + 9 + 9 = 19.
  - o_unit_light stays stable while in WAIT.
- **Reset mid-run.** Assert i_rstn = 0 during WAIT of light 2 of 4.
  - All outputs at reset values the next cycle; no o_valid.
  - A new request after reset completes normally with freshly cleared accumulators.

Source files
------------

// File: rtl/bs_bp_shading_light_seq.sv
// Per-light shading sequencer: walks the light table, time-shares one shading unit,
// and folds the saturated per-light RGB sum plus ambient into one clamped result.
module bs_bp_shading_light_seq #(
    parameter int MAX_L = 8,
    parameter int LEN_N = $clog2(MAX_L + 1),
    parameter int LEN_A = $clog2(MAX_L)
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_en,
    input  logic        [LEN_N-1:0] i_num_lights,
    input  logic signed [31:0]      i_amb_light     [0:2],
    output logic        [LEN_A-1:0] o_light_rd_addr,
    input  logic signed [31:0]      i_light_rd_data [0:1][0:2],
    output logic signed [31:0]      o_unit_light    [0:1][0:2],
    output logic                    o_unit_en,
    input  logic signed [31:0]      i_unit_light    [0:2],
    input  logic                    i_unit_valid,
    output logic signed [31:0]      o_light         [0:2],
    output logic                    o_busy,
    output logic                    o_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LATCH,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [LEN_N-1:0]   r_count;
    logic [LEN_N-1:0]   r_idx;
    logic signed [31:0] r_amb [0:2];
    logic [15:0]        r_acc [0:2];

    logic [LEN_N-1:0]   w_num;
    logic               w_more;
    logic [15:0]        w_acc_next [0:2];
    logic [31:0]        w_final    [0:2];

    assign w_num  = (i_num_lights > LEN_N'(MAX_L)) ? LEN_N'(MAX_L) : i_num_lights;
    assign w_more = ({1'b0, r_idx} + 1'b1) < {1'b0, r_count};
    assign o_light_rd_addr = (r_state == S_IDLE) ? '0 : r_idx[LEN_A-1:0];

    // The final value is formed from the accumulator as it will be after this
    // cycle's update, so a zero-light request sees ambient plus zero.
    for (genvar c = 0; c < 3; c++) begin : g_ch
        logic        [32:0] w_term;
        logic        [32:0] w_sum;
        logic        [32:0] w_total;
        logic signed [31:0] w_amb_sel;
        logic        [15:0] w_acc_sel;

        assign w_term        = i_unit_light[c][31] ? 33'd0 : {1'b0, i_unit_light[c]};
        assign w_sum         = {17'd0, r_acc[c]} + w_term;
        assign w_acc_next[c] = (w_sum[32:16] != '0) ? 16'hffff : w_sum[15:0];
        assign w_amb_sel     = (r_state == S_IDLE) ? i_amb_light[c] : r_amb[c];
        assign w_acc_sel     = (r_state == S_WAIT) ? w_acc_next[c] : 16'd0;
        assign w_total       = {w_amb_sel[31], w_amb_sel} + {17'd0, w_acc_sel};
        assign w_final[c]    = w_total[32] ? 32'd0 :
                               (w_total[31:16] != '0) ? 32'h0000ffff :
                               {16'd0, w_total[15:0]};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_idx     <= '0;
            o_unit_en <= 1'b0;
            o_busy    <= 1'b0;
            o_valid   <= 1'b0;
            for (int c = 0; c < 3; c++) begin
                r_amb[c]           <= '0;
                r_acc[c]           <= '0;
                o_light[c]         <= '0;
                o_unit_light[0][c] <= '0;
                o_unit_light[1][c] <= '0;
            end
        end else begin
            o_unit_en <= 1'b0;
            o_valid   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_en) begin
                        r_count <= w_num;
                        r_idx   <= '0;
                        o_busy  <= 1'b1;
                        for (int c = 0; c < 3; c++) begin
                            r_amb[c] <= i_amb_light[c];
                            r_acc[c] <= '0;
                        end
                        if (w_num != '0) begin
                            r_state <= S_RD;
                        end else begin
                            r_state <= S_DONE;
                            o_valid <= 1'b1;
                            for (int c = 0; c < 3; c++) o_light[c] <= w_final[c];
                        end
                    end
                end
                S_RD: r_state <= S_LATCH;
                S_LATCH: begin
                    o_unit_light <= i_light_rd_data;
                    o_unit_en    <= 1'b1;
                    r_state      <= S_ISSUE;
                end
                S_ISSUE: r_state <= S_WAIT;
                S_WAIT: begin
                    if (i_unit_valid) begin
                        r_idx <= r_idx + 1'b1;
                        for (int c = 0; c < 3; c++) r_acc[c] <= w_acc_next[c];
                        if (w_more) begin
                            r_state <= S_RD;
                        end else begin
                            r_state <= S_DONE;
                            o_valid <= 1'b1;
                            for (int c = 0; c < 3; c++) o_light[c] <= w_final[c];
                        end
                    end
                end
                S_DONE: begin
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bs_bp_shading_light_seq.sv
// Self-checking bench for bs_bp_shading_light_seq: a cycle-schedule model built from
// per-light latencies, plus emulated light table and shared unit.
module tb_bs_bp_shading_light_seq;

    localparam int MAX_L = 8;
    localparam int LEN_N = 4;
    localparam int LEN_A = 3;
    localparam int HORIZON = 256;

    logic                    i_clk = 1'b0;
    logic                    i_rstn;
    logic                    i_en;
    logic        [LEN_N-1:0] i_num_lights;
    logic signed [31:0]      i_amb_light     [0:2];
    logic        [LEN_A-1:0] o_light_rd_addr;
    logic signed [31:0]      i_light_rd_data [0:1][0:2];
    logic signed [31:0]      o_unit_light    [0:1][0:2];
    logic                    o_unit_en;
    logic signed [31:0]      i_unit_light    [0:2];
    logic                    i_unit_valid;
    logic signed [31:0]      o_light         [0:2];
    logic                    o_busy;
    logic                    o_valid;

    bs_bp_shading_light_seq #(.MAX_L(MAX_L)) dut (
        .i_clk          (i_clk),
        .i_rstn         (i_rstn),
        .i_en           (i_en),
        .i_num_lights   (i_num_lights),
        .i_amb_light    (i_amb_light),
        .o_light_rd_addr(o_light_rd_addr),
        .i_light_rd_data(i_light_rd_data),
        .o_unit_light   (o_unit_light),
        .o_unit_en      (o_unit_en),
        .i_unit_light   (i_unit_light),
        .i_unit_valid   (i_unit_valid),
        .o_light        (o_light),
        .o_busy         (o_busy),
        .o_valid        (o_valid)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int passCount = 0;
    int checkCount = 0;

    // Request plan handed to the model and the emulators
    int                 planN;
    int                 planLat [MAX_L];
    longint             planRes [MAX_L][3];
    longint             planAmb [3];
    logic signed [31:0] tbl     [MAX_L][2][3];
    int                 strayRel;
    int                 secondEnRel;
    int                 resetRel;

    // Expected per-cycle view, indexed by cycle relative to the i_en cycle
    bit     expValid [HORIZON];
    bit     expBusy  [HORIZON];
    bit     expEn    [HORIZON];
    int     expAddr  [HORIZON];
    int     expUnit  [HORIZON];
    longint expLight [HORIZON][3];
    longint prevLight [3];
    int     expValidRel;

    int t0 = 0;
    bit armed = 1'b0;
    int obsValidCyc = -1;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checkCount++;
        if (act == exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model: schedule from RD/LATCH/ISSUE + L_u wait cycles per light, result from
    // saturating accumulation of non-negative terms and a clamped ambient add.
    task automatic buildPlan();
        int n, rel, en;
        longint acc [3];
        longint t, tot;
        n = (planN > MAX_L) ? MAX_L : planN;
        for (int r = 0; r < HORIZON; r++) begin
            expValid[r] = 0; expBusy[r] = 0; expEn[r] = 0;
            expAddr[r] = -1; expUnit[r] = -1;
            for (int c = 0; c < 3; c++) expLight[r][c] = prevLight[c];
        end
        for (int c = 0; c < 3; c++) acc[c] = 0;
        rel = 1;
        for (int k = 0; k < n; k++) begin
            expAddr[rel] = k;
            en = rel + 2;
            expEn[en] = 1;
            for (int w = 1; w <= planLat[k]; w++) expUnit[en + w] = k;
            for (int c = 0; c < 3; c++) begin
                t = (planRes[k][c] < 0) ? 0 : planRes[k][c];
                acc[c] = acc[c] + t;
                if (acc[c] > 65535) acc[c] = 65535;
            end
            rel = en + planLat[k] + 1;
        end
        expValidRel = rel;
        expValid[rel] = 1;
        for (int r = 1; r <= rel; r++) expBusy[r] = 1;
        for (int c = 0; c < 3; c++) begin
            tot = planAmb[c] + acc[c];
            if (tot < 0) tot = 0;
            if (tot > 65535) tot = 65535;
            for (int r = rel; r < HORIZON; r++) expLight[r][c] = tot;
            prevLight[c] = tot;
        end
        if (resetRel >= 0) begin
            for (int r = resetRel + 1; r < HORIZON; r++) begin
                expValid[r] = 0; expBusy[r] = 0; expEn[r] = 0;
                expAddr[r] = -1; expUnit[r] = -1;
                for (int c = 0; c < 3; c++) expLight[r][c] = 0;
            end
            for (int c = 0; c < 3; c++) prevLight[c] = 0;
        end
    endtask

    // Single compare process: every cycle the outputs are checked against the model
    always @(negedge i_clk) begin
        if (armed) begin
            int rel;
            rel = cyc - t0;
            if (rel >= HORIZON || rel < 0) rel = HORIZON - 1;
            checkOutput("o_valid", longint'(o_valid), longint'(expValid[rel]));
            checkOutput("o_busy", longint'(o_busy), longint'(expBusy[rel]));
            checkOutput("o_unit_en", longint'(o_unit_en), longint'(expEn[rel]));
            if (expAddr[rel] >= 0)
                checkOutput("o_light_rd_addr", longint'(o_light_rd_addr), longint'(expAddr[rel]));
            if (expUnit[rel] >= 0)
                for (int s = 0; s < 2; s++)
                    for (int c = 0; c < 3; c++)
                        checkOutput("o_unit_light", longint'(o_unit_light[s][c]),
                                    longint'(tbl[expUnit[rel]][s][c]));
            for (int c = 0; c < 3; c++)
                checkOutput("o_light", longint'(o_light[c]), expLight[rel][c]);
            if (o_valid) obsValidCyc = cyc;
        end
    end

    task automatic clearPlan();
        strayRel = -1; secondEnRel = -1; resetRel = -1;
        for (int k = 0; k < MAX_L; k++) begin
            planLat[k] = 1;
            for (int c = 0; c < 3; c++) begin
                planRes[k][c] = 0;
                tbl[k][0][c] = $urandom;
                tbl[k][1][c] = $urandom;
            end
        end
        for (int c = 0; c < 3; c++) planAmb[c] = 0;
    endtask

    // Drives one request and emulates the light table and the shared unit
    task automatic applyStimulus();
        int endRel, enCount, pendAt, pendIdx;
        @(negedge i_clk); #2;
        buildPlan();
        t0 = cyc;
        i_en = 1'b1;
        i_num_lights = LEN_N'(planN);
        for (int c = 0; c < 3; c++) i_amb_light[c] = planAmb[c][31:0];
        i_unit_valid = 1'b0;
        enCount = 0; pendAt = -1; pendIdx = 0;
        endRel = (resetRel >= 0) ? resetRel + 1 : expValidRel;
        for (int rel = 1; rel <= endRel; rel++) begin
            @(negedge i_clk); #2;
            i_en   = (rel == secondEnRel);
            i_rstn = (rel != resetRel);
            for (int s = 0; s < 2; s++)
                for (int c = 0; c < 3; c++)
                    i_light_rd_data[s][c] = tbl[o_light_rd_addr][s][c];
            if (o_unit_en && enCount < MAX_L) begin
                pendIdx = enCount;
                enCount++;
                pendAt = rel + planLat[pendIdx];
            end
            if (rel == pendAt) begin
                i_unit_valid = 1'b1;
                for (int c = 0; c < 3; c++) i_unit_light[c] = planRes[pendIdx][c][31:0];
            end else if (rel == strayRel) begin
                i_unit_valid = 1'b1;
                for (int c = 0; c < 3; c++) i_unit_light[c] = 32'sh00001234;
            end else begin
                i_unit_valid = 1'b0;
                for (int c = 0; c < 3; c++) i_unit_light[c] = 32'sh00005555;
            end
        end
        i_en = 1'b0;
    endtask

    task automatic directedCheck(input string name, input int vrel,
                                 input longint l0, input longint l1, input longint l2);
        checkOutput({name, "_valid_cycle"}, longint'(obsValidCyc - t0), longint'(vrel));
        checkOutput({name, "_r"}, longint'(o_light[0]), l0);
        checkOutput({name, "_g"}, longint'(o_light[1]), l1);
        checkOutput({name, "_b"}, longint'(o_light[2]), l2);
    endtask

    initial begin
        i_rstn = 1'b0; i_en = 1'b0; i_num_lights = '0; i_unit_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            i_amb_light[c] = '0; i_unit_light[c] = '0;
            i_light_rd_data[0][c] = '0; i_light_rd_data[1][c] = '0;
            prevLight[c] = 0;
        end
        repeat (3) @(negedge i_clk);
        checkOutput("reset_valid", longint'(o_valid), 0);
        checkOutput("reset_busy", longint'(o_busy), 0);
        checkOutput("reset_unit_en", longint'(o_unit_en), 0);
        checkOutput("reset_addr", longint'(o_light_rd_addr), 0);
        for (int c = 0; c < 3; c++) begin
            checkOutput("reset_light", longint'(o_light[c]), 0);
            checkOutput("reset_unit_light0", longint'(o_unit_light[0][c]), 0);
            checkOutput("reset_unit_light1", longint'(o_unit_light[1][c]), 0);
        end
        #2;
        i_rstn = 1'b1;
        clearPlan();
        planN = 0;
        buildPlan();
        t0 = cyc - HORIZON;
        armed = 1'b1;

        // Single light
        clearPlan();
        planN = 1; planLat[0] = 2;
        for (int c = 0; c < 3; c++) planAmb[c] = 'h2000;
        planRes[0][0] = 'h4000; planRes[0][1] = 'h1000; planRes[0][2] = 0;
        applyStimulus();
        directedCheck("single", 6, 'h6000, 'h3000, 'h2000);

        // Zero lights, back-to-back with the previous request
        clearPlan();
        planN = 0;
        planAmb[0] = 'h1000; planAmb[1] = 'h2000; planAmb[2] = 'h3000;
        applyStimulus();
        directedCheck("zero", 1, 'h1000, 'h2000, 'h3000);

        // Saturation
        clearPlan();
        planN = 4;
        for (int k = 0; k < 4; k++) for (int c = 0; c < 3; c++) planRes[k][c] = 'h8000;
        applyStimulus();
        directedCheck("saturate", 17, 'hffff, 'hffff, 'hffff);

        // Negative ambient and negative unit term
        clearPlan();
        planN = 2; planLat[1] = 2;
        planAmb[0] = -'h4000;
        planRes[0][0] = -'h8000; planRes[0][1] = 'h1000; planRes[0][2] = 0;
        planRes[1][0] = 'h2000;  planRes[1][1] = 'h1000; planRes[1][2] = 'h1000;
        applyStimulus();
        directedCheck("negative", 10, 0, 'h2000, 'h1000);

        // Stray valid in RD, second i_en while busy, varying unit latency
        clearPlan();
        planN = 3; planLat[0] = 1; planLat[1] = 5; planLat[2] = 3;
        for (int c = 0; c < 3; c++) begin
            planAmb[c] = 'h10;
            planRes[0][c] = 'h100; planRes[1][c] = 'h200; planRes[2][c] = 'h300;
        end
        strayRel = 5; secondEnRel = 3;
        applyStimulus();
        directedCheck("robust", 19, 'h610, 'h610, 'h610);

        // Reset during WAIT of the second of four lights
        clearPlan();
        planN = 4;
        for (int k = 0; k < 4; k++) begin
            planLat[k] = 2;
            for (int c = 0; c < 3; c++) planRes[k][c] = 'h700;
        end
        resetRel = 9;
        applyStimulus();
        clearPlan();
        planN = 2;
        for (int c = 0; c < 3; c++) begin planRes[0][c] = 'h10; planRes[1][c] = 'h20; end
        applyStimulus();
        directedCheck("after_reset", 9, 'h30, 'h30, 'h30);

        // Light count above MAX_L is clamped
        clearPlan();
        planN = 12;
        for (int k = 0; k < MAX_L; k++) for (int c = 0; c < 3; c++) planRes[k][c] = 'h100;
        applyStimulus();
        directedCheck("clamp_n", 33, 'h800, 'h800, 'h800);

        // Randomized requests
        for (int r = 0; r < 30; r++) begin
            clearPlan();
            planN = $urandom_range(0, 10);
            for (int c = 0; c < 3; c++) planAmb[c] = longint'($urandom_range(0, 'h18000)) - 'h8000;
            for (int k = 0; k < MAX_L; k++) begin
                planLat[k] = $urandom_range(1, 6);
                for (int c = 0; c < 3; c++) begin
                    int cat;
                    cat = $urandom_range(0, 9);
                    if (cat < 6)       planRes[k][c] = longint'($urandom_range(0, 'h6000));
                    else if (cat < 8)  planRes[k][c] = -longint'($urandom_range(1, 'h10000));
                    else if (cat == 8) planRes[k][c] = longint'($urandom_range('h10000, 'h7fffffff));
                    else               planRes[k][c] = -longint'($urandom_range(1, 'h7fffffff));
                end
            end
            if ($urandom_range(0, 3) == 0) secondEnRel = 2;
            applyStimulus();
        end

        repeat (3) @(negedge i_clk);
        #2;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
